pea_top_module_1: RTL and testbench

PEA_TOP_MODULE_1 -- requirements
Module: pea_top_module_1

---
 rtl/pea_top_module_1.sv | 203 ++++++++++++++++++++
 tb/tb_pea_top_module_1.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pea_top_module_1.sv
// Polynomial evaluation actor: decodes commands from a command FIFO, stores up to eight
// polynomials (STP), evaluates them by Horner's rule (EVP), clears them (RST), reports results.
module pea_top_module_1 #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned BUFFER_SIZE = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WIDTH-1:0]               data_in_fifo_command,
  input  logic [WIDTH-1:0]               data_in_fifo_data,
  input  logic                           invoke,
  input  logic [1:0]                     next_instr,
  input  logic [$clog2(BUFFER_SIZE)-1:0] data_pop,
  input  logic [$clog2(BUFFER_SIZE)-1:0] command_pop,
  output logic                           rd_in_command,
  output logic                           rd_in_data,
  output logic                           FC,
  output logic                           wr_out,
  output logic [31:0]                    data_out_result,
  output logic [31:0]                    data_out_status,
  output logic [7:0]                     instr,
  output logic [4:0]                     arg2
);

  localparam logic [7:0] OpStp = 8'h01;
  localparam logic [7:0] OpEvp = 8'h02;
  localparam logic [7:0] OpRst = 8'h04;

  typedef enum logic [2:0] {StIdle, StGc, StExec, StOut, StDone} state_e;

  state_e      state_q;
  logic        rd_cmd_q, rd_data_q, fc_q, wr_q;
  logic [31:0] res_out_q, stat_out_q;
  logic [7:0]  instr_q;
  logic [2:0]  b_q;
  logic [4:0]  arg2_q;
  logic [31:0] result_q, acc_q, x_q;
  logic        error_q;
  logic [3:0]  step_q, idx_q;
  logic [15:0] coef_q [8][11];
  logic [3:0]  deg_q [8];
  logic [7:0]  valid_q;

  logic        stp_ok;
  logic [3:0]  cidx;
  logic [31:0] c_ext, cn_ext, horner;
  logic        unused_pop;

  assign unused_pop = ^{data_pop, command_pop};
  assign stp_ok     = (arg2_q <= 5'd10);
  assign cidx       = idx_q - 4'd1;
  assign c_ext      = {{16{coef_q[b_q][cidx][15]}}, coef_q[b_q][cidx]};
  assign cn_ext     = {{16{coef_q[b_q][deg_q[b_q]][15]}}, coef_q[b_q][deg_q[b_q]]};
  // Low 32 bits of the product are identical for signed and unsigned operands.
  assign horner     = acc_q * x_q + c_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rd_cmd_q   <= 1'b0;
      rd_data_q  <= 1'b0;
      fc_q       <= 1'b0;
      wr_q       <= 1'b0;
      res_out_q  <= '0;
      stat_out_q <= '0;
      instr_q    <= '0;
      b_q        <= '0;
      arg2_q     <= '0;
      result_q   <= '0;
      error_q    <= 1'b0;
      acc_q      <= '0;
      x_q        <= '0;
      step_q     <= '0;
      idx_q      <= '0;
      valid_q    <= '0;
      deg_q      <= '{default: '0};
    end else begin
      rd_cmd_q  <= 1'b0;
      rd_data_q <= 1'b0;
      fc_q      <= 1'b0;
      wr_q      <= 1'b0;
      case (state_q)
        StIdle: begin
          if (invoke) begin
            step_q <= '0;
            unique case (next_instr)
              2'b00: begin
                state_q  <= StGc;
                rd_cmd_q <= 1'b1;
              end
              2'b01: begin
                state_q   <= StExec;
                rd_data_q <= (instr_q == OpEvp) || ((instr_q == OpStp) && stp_ok);
              end
              2'b10: begin
                state_q    <= StOut;
                wr_q       <= 1'b1;
                res_out_q  <= result_q;
                stat_out_q <= {instr_q, b_q, arg2_q, 15'b0, error_q};
              end
              default: begin
                state_q <= StDone;
                fc_q    <= 1'b1;
              end
            endcase
          end
        end
        StGc: begin
          step_q <= step_q + 4'd1;
          // The popped word is at the FIFO head one cycle after the strobe.
          if (step_q == 4'd1) begin
            instr_q <= data_in_fifo_command[7:0];
            b_q     <= data_in_fifo_command[10:8];
            arg2_q  <= data_in_fifo_command[15:11];
            state_q <= StDone;
            fc_q    <= 1'b1;
          end
        end
        StExec: begin
          case (instr_q)
            OpStp: begin
              if (!stp_ok) begin
                result_q <= '0;
                error_q  <= 1'b1;
                state_q  <= StDone;
                fc_q     <= 1'b1;
              end else begin
                if (step_q != 4'd0) coef_q[b_q][step_q - 4'd1] <= data_in_fifo_data[15:0];
                if (step_q == arg2_q[3:0] + 4'd1) begin
                  deg_q[b_q]   <= arg2_q[3:0];
                  valid_q[b_q] <= 1'b1;
                  result_q     <= '0;
                  error_q      <= 1'b0;
                  state_q      <= StDone;
                  fc_q         <= 1'b1;
                end else begin
                  rd_data_q <= (step_q < arg2_q[3:0]);
                  step_q    <= step_q + 4'd1;
                end
              end
            end
            OpEvp: begin
              if (step_q == 4'd0) begin
                step_q <= 4'd1;
              end else if (step_q == 4'd1) begin
                x_q <= {{16{data_in_fifo_data[15]}}, data_in_fifo_data[15:0]};
                if (!valid_q[b_q]) begin
                  result_q <= '0;
                  error_q  <= 1'b1;
                  state_q  <= StDone;
                  fc_q     <= 1'b1;
                end else begin
                  acc_q  <= cn_ext;
                  idx_q  <= deg_q[b_q];
                  step_q <= 4'd2;
                end
              end else if (idx_q == 4'd0) begin
                result_q <= acc_q;
                error_q  <= 1'b0;
                state_q  <= StDone;
                fc_q     <= 1'b1;
              end else begin
                acc_q <= horner;
                idx_q <= idx_q - 4'd1;
              end
            end
            OpRst: begin
              for (int k = 0; k < 11; k++) coef_q[b_q][k] <= '0;
              deg_q[b_q]   <= '0;
              valid_q[b_q] <= 1'b0;
              result_q     <= '0;
              error_q      <= 1'b0;
              state_q      <= StDone;
              fc_q         <= 1'b1;
            end
            default: begin
              result_q <= '0;
              error_q  <= 1'b1;
              state_q  <= StDone;
              fc_q     <= 1'b1;
            end
          endcase
        end
        StOut: begin
          state_q <= StDone;
          fc_q    <= 1'b1;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rd_in_command   = rd_cmd_q;
  assign rd_in_data      = rd_data_q;
  assign FC              = fc_q;
  assign wr_out          = wr_q;
  assign data_out_result = res_out_q;
  assign data_out_status = stat_out_q;
  assign instr           = instr_q;
  assign arg2            = arg2_q;

endmodule

// File: tb/tb_pea_top_module_1.sv
// Bench for pea_top_module_1: FIFO models, directed vector table, randomized commands
// against a polynomial-sum reference model, and reset corner cases.
module tb_pea_top_module_1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        invoke = 1'b0;
  logic [1:0]  next_instr = 2'b11;
  logic [15:0] cmd_head = '0, dat_head = '0;
  logic [9:0]  data_pop = '0, command_pop = '0;
  logic        rd_in_command, rd_in_data, FC, wr_out;
  logic [31:0] data_out_result, data_out_status;
  logic [7:0]  instr;
  logic [4:0]  arg2;

  int checks = 0;
  int failures = 0;

  logic [15:0] cmd_fifo[$];
  logic [15:0] dat_fifo[$];
  logic [15:0] wbuf[11];

  int mc[8][11];
  int mdeg[8];
  bit mval[8];

  pea_top_module_1 dut (
    .clk                 (clk),
    .rst                 (rst),
    .data_in_fifo_command(cmd_head),
    .data_in_fifo_data   (dat_head),
    .invoke              (invoke),
    .next_instr          (next_instr),
    .data_pop            (data_pop),
    .command_pop         (command_pop),
    .rd_in_command       (rd_in_command),
    .rd_in_data          (rd_in_data),
    .FC                  (FC),
    .wr_out              (wr_out),
    .data_out_result     (data_out_result),
    .data_out_status     (data_out_status),
    .instr               (instr),
    .arg2                (arg2)
  );

  always #5 clk = ~clk;

  // FIFO heads update on the edge that samples a pop strobe.
  always @(posedge clk) begin
    if (rd_in_command) begin
      if (cmd_fifo.size() > 0) cmd_head <= cmd_fifo.pop_front();
      else cmd_head <= 16'h0;
    end
    if (rd_in_data) begin
      if (dat_fifo.size() > 0) dat_head <= dat_fifo.pop_front();
      else dat_head <= 16'h0;
    end
    data_pop    <= 10'(dat_fifo.size());
    command_pop <= 10'(cmd_fifo.size());
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input logic [15:0] cmd, input bit err);
    return {cmd[7:0], cmd[10:8], cmd[15:11], 15'b0, err};
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 8; p++) begin
      mval[p] = 0;
      mdeg[p] = 0;
      for (int i = 0; i < 11; i++) mc[p][i] = 0;
    end
  endtask

  // Result is sum(c_i * x^i) in wrapping 32-bit int arithmetic.
  task automatic model_exec(input logic [15:0] cmd, output int pops, output int res,
                            output bit err);
    int b, n, x, acc, xp;
    b = int'(cmd[10:8]);
    n = int'(cmd[15:11]);
    pops = 0; res = 0; err = 1;
    case (cmd[7:0])
      8'h01: if (n <= 10) begin
        for (int i = 0; i <= n; i++) mc[b][i] = int'($signed(wbuf[i]));
        mdeg[b] = n; mval[b] = 1; pops = n + 1; err = 0;
      end
      8'h02: begin
        pops = 1;
        if (mval[b]) begin
          x = int'($signed(wbuf[0])); acc = 0; xp = 1;
          for (int i = 0; i <= mdeg[b]; i++) begin
            acc = acc + mc[b][i] * xp;
            xp = xp * x;
          end
          res = acc; err = 0;
        end
      end
      8'h04: begin
        for (int i = 0; i < 11; i++) mc[b][i] = 0;
        mdeg[b] = 0; mval[b] = 0; err = 0;
      end
      default: ;
    endcase
  endtask

  task automatic fire(input logic [1:0] mode, output int n_cmd, output int n_dat,
                      output int n_wr, output logic [31:0] res, output logic [31:0] st,
                      output bit fc_seen, output bit fc_extra);
    n_cmd = 0; n_dat = 0; n_wr = 0; res = '0; st = '0; fc_seen = 0;
    @(negedge clk);
    invoke = 1'b1;
    next_instr = mode;
    for (int c = 0; c < 100 && !fc_seen; c++) begin
      @(negedge clk);
      invoke = 1'b0;
      chk("one_pop_strobe", 32'(rd_in_command & rd_in_data), 32'h0);
      if (rd_in_command) n_cmd++;
      if (rd_in_data) n_dat++;
      if (wr_out) begin
        n_wr++;
        res = data_out_result;
        st  = data_out_status;
      end
      if (FC) fc_seen = 1;
    end
    @(negedge clk);
    fc_extra = FC;
  endtask

  task automatic run_cmd(input logic [15:0] cmd, input int nw, output int pops,
                         output logic [31:0] res, output logic [31:0] st);
    int nc, nd, nwr;
    logic [31:0] r, s;
    bit fc, ex;
    dat_fifo.delete();
    cmd_fifo.push_back(cmd);
    fire(2'b00, nc, nd, nwr, r, s, fc, ex);
    chk("gc_fc", 32'(fc), 32'h1);
    chk("gc_fc_width", 32'(ex), 32'h0);
    chk("gc_cmd_pops", nc, 1);
    chk("gc_data_pops", nd, 0);
    chk("gc_instr", 32'(instr), 32'(cmd[7:0]));
    chk("gc_arg2", 32'(arg2), 32'(cmd[15:11]));
    for (int j = 0; j < nw; j++) dat_fifo.push_back(wbuf[j]);
    fire(2'b01, nc, nd, nwr, r, s, fc, ex);
    chk("exec_fc", 32'(fc), 32'h1);
    chk("exec_cmd_pops", nc, 0);
    chk("exec_wr", nwr, 0);
    pops = nd;
    fire(2'b10, nc, nd, nwr, r, s, fc, ex);
    chk("out_fc", 32'(fc), 32'h1);
    chk("out_wr_count", nwr, 1);
    chk("out_pops", nc + nd, 0);
    res = r;
    st  = s;
  endtask

  typedef struct packed {
    logic [15:0] cmd;
    logic [3:0]  nw;
    logic [15:0] w0, w1, w2, fill;
    logic [3:0]  pops;
    logic [31:0] res;
    logic        err;
  } vec_t;

  function automatic vec_t mkv(input logic [15:0] cmd, input logic [3:0] nw,
                               input logic [15:0] w0, input logic [15:0] w1,
                               input logic [15:0] w2, input logic [15:0] fill,
                               input logic [3:0] pops, input logic [31:0] res, input logic err);
    vec_t v;
    v.cmd = cmd; v.nw = nw; v.w0 = w0; v.w1 = w1; v.w2 = w2; v.fill = fill;
    v.pops = pops; v.res = res; v.err = err;
    return v;
  endfunction

  localparam int NV = 13;
  vec_t tbl[NV];

  initial begin
    int pops, mp, mr, nc, nd, nwr, n, op;
    bit me, fc, ex;
    logic [31:0] res, st, r, s;
    logic [15:0] cmd;
    logic [2:0] b;

    tbl[0]  = mkv(16'h1101, 4'd3,  16'd3,    16'd2,    16'd1, 16'd0, 4'd3,  32'h0, 1'b0);
    tbl[1]  = mkv(16'h0102, 4'd1,  16'd2,    16'd0,    16'd0, 16'd0, 4'd1,  32'hB, 1'b0);
    tbl[2]  = mkv(16'h0502, 4'd1,  16'd7,    16'd0,    16'd0, 16'd0, 4'd1,  32'h0, 1'b1);
    tbl[3]  = mkv(16'h0104, 4'd0,  16'd0,    16'd0,    16'd0, 16'd0, 4'd0,  32'h0, 1'b0);
    tbl[4]  = mkv(16'h0102, 4'd1,  16'd2,    16'd0,    16'd0, 16'd0, 4'd1,  32'h0, 1'b1);
    tbl[5]  = mkv(16'h00FF, 4'd0,  16'd0,    16'd0,    16'd0, 16'd0, 4'd0,  32'h0, 1'b1);
    tbl[6]  = mkv(16'h5801, 4'd0,  16'd0,    16'd0,    16'd0, 16'd0, 4'd0,  32'h0, 1'b1);
    tbl[7]  = mkv(16'h0201, 4'd1,  16'hFFFB, 16'd0,    16'd0, 16'd0, 4'd1,  32'h0, 1'b0);
    tbl[8]  = mkv(16'h0202, 4'd1,  16'd100,  16'd0,    16'd0, 16'd0, 4'd1,  32'hFFFFFFFB, 1'b0);
    tbl[9]  = mkv(16'h5301, 4'd11, 16'd1,    16'd1,    16'd1, 16'd1, 4'd11, 32'h0, 1'b0);
    tbl[10] = mkv(16'h0302, 4'd1,  16'd2,    16'd0,    16'd0, 16'd0, 4'd1,  32'h7FF, 1'b0);
    tbl[11] = mkv(16'h0C01, 4'd2,  16'h8000, 16'h7FFF, 16'd0, 16'd0, 4'd2,  32'h0, 1'b0);
    tbl[12] = mkv(16'h0402, 4'd1,  16'h8000, 16'd0,    16'd0, 16'd0, 4'd1,  32'hC0000000, 1'b0);

    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_fc", 32'(FC), 32'h0);
    chk("rst_wr_out", 32'(wr_out), 32'h0);
    chk("rst_rd_cmd", 32'(rd_in_command), 32'h0);
    chk("rst_rd_data", 32'(rd_in_data), 32'h0);
    chk("rst_result", data_out_result, 32'h0);
    chk("rst_status", data_out_status, 32'h0);
    chk("rst_instr", 32'(instr), 32'h0);
    chk("rst_arg2", 32'(arg2), 32'h0);
    rst = 1'b0;

    // Fetch of a lone RST command word.
    cmd_fifo.push_back(16'h0004);
    fire(2'b00, nc, nd, nwr, r, s, fc, ex);
    chk("gc_only_fc", 32'(fc), 32'h1);
    chk("gc_only_cmd_pops", nc, 1);
    chk("gc_only_instr", 32'(instr), 32'h04);
    chk("gc_only_arg2", 32'(arg2), 32'h0);

    // No-op firing: straight to DONE with no strobes.
    fire(2'b11, nc, nd, nwr, r, s, fc, ex);
    chk("noop_fc", 32'(fc), 32'h1);
    chk("noop_strobes", nc + nd + nwr, 0);
    chk("noop_fc_width", 32'(ex), 32'h0);

    for (int i = 0; i < NV; i++) begin
      for (int j = 0; j < 11; j++)
        wbuf[j] = (j == 0) ? tbl[i].w0 : (j == 1) ? tbl[i].w1 : (j == 2) ? tbl[i].w2 : tbl[i].fill;
      model_exec(tbl[i].cmd, mp, mr, me);
      run_cmd(tbl[i].cmd, int'(tbl[i].nw), pops, res, st);
      chk($sformatf("vec%0d_pops", i), pops, 32'(tbl[i].pops));
      chk($sformatf("vec%0d_result", i), res, tbl[i].res);
      chk($sformatf("vec%0d_status", i), st, exp_status(tbl[i].cmd, tbl[i].err));
    end

    for (int it = 0; it < 50; it++) begin
      b  = 3'($urandom_range(0, 7));
      op = int'($urandom_range(0, 9));
      n  = 0;
      for (int j = 0; j < 11; j++) wbuf[j] = 16'($urandom);
      if (op <= 3) begin
        n = int'($urandom_range(0, 10));
        cmd = {5'(n), b, 8'h01};
      end else if (op <= 6) begin
        if (op == 4) wbuf[0] = 16'($urandom_range(0, 6)) - 16'd3;
        cmd = {5'($urandom), b, 8'h02};
      end else if (op == 7) begin
        cmd = {5'($urandom), b, 8'h04};
      end else if (op == 8) begin
        cmd = {5'($urandom), b, 8'($urandom_range(5, 255))};
      end else begin
        n = int'($urandom_range(11, 31));
        cmd = {5'(n), b, 8'h01};
      end
      model_exec(cmd, mp, mr, me);
      run_cmd(cmd, mp, pops, res, st);
      chk($sformatf("rnd%0d_pops cmd=%04h", it, cmd), pops, mp);
      chk($sformatf("rnd%0d_result cmd=%04h", it, cmd), res, mr);
      chk($sformatf("rnd%0d_status cmd=%04h", it, cmd), st, exp_status(cmd, me));
    end

    // Reset during an STP: firing aborts silently and all polynomials become invalid.
    dat_fifo.delete();
    cmd_fifo.push_back(16'h2901);
    fire(2'b00, nc, nd, nwr, r, s, fc, ex);
    for (int j = 0; j < 6; j++) dat_fifo.push_back(16'(j + 1));
    nc = 0;
    @(negedge clk);
    invoke = 1'b1;
    next_instr = 2'b01;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      invoke = 1'b0;
      if (c == 2) rst = 1'b1;
      if (c == 4) rst = 1'b0;
      if (FC || wr_out) nc++;
    end
    chk("midrst_no_fc_wr", nc, 0);
    chk("midrst_rd_data", 32'(rd_in_data), 32'h0);
    chk("midrst_instr", 32'(instr), 32'h0);
    chk("midrst_status", data_out_status, 32'h0);
    model_reset();
    wbuf[0] = 16'd2;
    model_exec(16'h0102, mp, mr, me);
    run_cmd(16'h0102, 1, pops, res, st);
    chk("midrst_evp_pops", pops, 1);
    chk("midrst_evp_status", st, exp_status(16'h0102, 1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
